// File: rtl/axi4_lite_master_bridge.sv
// Native valid/ready request -> single-outstanding AXI4-Lite master.
// Every AXI and native-side output comes straight from a flop.
module axi4_lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  // native request
  input  logic                    iREQ_VALID,
  output logic                    oREQ_READY,
  input  logic                    iREQ_WRITE,
  input  logic [ADDR_WIDTH-1:0]   iREQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   iREQ_WDATA,
  input  logic [DATA_WIDTH/8-1:0] iREQ_WSTRB,
  // native response
  output logic                    oRSP_VALID,
  input  logic                    iRSP_READY,
  output logic [DATA_WIDTH-1:0]   oRSP_RDATA,
  output logic                    oRSP_ERR,
  // AXI4-Lite write address
  output logic                    m_AWVALID,
  input  logic                    m_AWREADY,
  output logic [ADDR_WIDTH-1:0]   m_AWADDR,
  output logic [2:0]              m_AWPROT,
  // AXI4-Lite write data
  output logic                    m_WVALID,
  input  logic                    m_WREADY,
  output logic [DATA_WIDTH-1:0]   m_WDATA,
  output logic [DATA_WIDTH/8-1:0] m_WSTRB,
  // AXI4-Lite write response
  input  logic                    m_BVALID,
  output logic                    m_BREADY,
  input  logic [1:0]              m_BRESP,
  // AXI4-Lite read address
  output logic                    m_ARVALID,
  input  logic                    m_ARREADY,
  output logic [ADDR_WIDTH-1:0]   m_ARADDR,
  output logic [2:0]              m_ARPROT,
  // AXI4-Lite read data
  input  logic                    m_RVALID,
  output logic                    m_RREADY,
  input  logic [DATA_WIDTH-1:0]   m_RDATA,
  input  logic [1:0]              m_RRESP
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  typedef struct packed {
    logic                  aw_valid;
    logic                  w_valid;
    logic                  b_ready;
    logic                  ar_valid;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
  } axi_t;

  typedef struct packed {
    logic                  req_ready;
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  state_t state_q, state_d;
  axi_t   axi_q, axi_d;
  rsp_t   rsp_q, rsp_d;
  logic   aw_done, w_done;

  // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic unused_resp_lsb;
  assign unused_resp_lsb = m_BRESP[0] ^ m_RRESP[0];

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= IDLE;
      axi_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      axi_q   <= axi_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    axi_d   = axi_q;
    rsp_d   = rsp_q;
    aw_done = 1'b0;
    w_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // ready comes up one edge after reset release, then stays up while idle
        rsp_d.req_ready = 1'b1;
        if (iREQ_VALID && rsp_q.req_ready) begin
          rsp_d.req_ready = 1'b0;
          if (iREQ_WRITE) begin
            state_d        = WR_REQ;
            axi_d.aw_valid = 1'b1;
            axi_d.w_valid  = 1'b1;
            axi_d.aw_addr  = iREQ_ADDR;
            axi_d.wdata    = iREQ_WDATA;
            axi_d.wstrb    = iREQ_WSTRB;
          end else begin
            state_d        = RD_REQ;
            axi_d.ar_valid = 1'b1;
            axi_d.ar_addr  = iREQ_ADDR;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; a channel already retired counts as done
        aw_done = !axi_q.aw_valid || m_AWREADY;
        w_done  = !axi_q.w_valid  || m_WREADY;
        if (m_AWREADY) axi_d.aw_valid = 1'b0;
        if (m_WREADY)  axi_d.w_valid  = 1'b0;
        if (aw_done && w_done) begin
          state_d       = WR_RESP;
          axi_d.b_ready = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_BVALID) begin
          state_d       = RESP;
          axi_d.b_ready = 1'b0;
          rsp_d.valid   = 1'b1;
          rsp_d.err     = m_BRESP[1];
          rsp_d.rdata   = '0;
        end
      end
      RD_REQ: begin
        if (m_ARREADY) begin
          state_d        = RD_DATA;
          axi_d.ar_valid = 1'b0;
          axi_d.r_ready  = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_RVALID) begin
          state_d       = RESP;
          axi_d.r_ready = 1'b0;
          rsp_d.valid   = 1'b1;
          rsp_d.err     = m_RRESP[1];
          rsp_d.rdata   = m_RDATA;
        end
      end
      RESP: begin
        if (iRSP_READY) begin
          state_d         = IDLE;
          rsp_d.valid     = 1'b0;
          rsp_d.req_ready = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        axi_d   = '0;
        rsp_d   = '0;
      end
    endcase
  end

  assign oREQ_READY = rsp_q.req_ready;
  assign oRSP_VALID = rsp_q.valid;
  assign oRSP_RDATA = rsp_q.rdata;
  assign oRSP_ERR   = rsp_q.err;

  assign m_AWVALID = axi_q.aw_valid;
  assign m_AWADDR  = axi_q.aw_addr;
  assign m_AWPROT  = 3'b000;
  assign m_WVALID  = axi_q.w_valid;
  assign m_WDATA   = axi_q.wdata;
  assign m_WSTRB   = axi_q.wstrb;
  assign m_BREADY  = axi_q.b_ready;
  assign m_ARVALID = axi_q.ar_valid;
  assign m_ARADDR  = axi_q.ar_addr;
  assign m_ARPROT  = 3'b000;
  assign m_RREADY  = axi_q.r_ready;

endmodule
